// File: rtl/pc_gen.sv
// Fetch-PC generator: sequences the fetch address, arbitrates redirects and buffers them across stalls.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                INC        = 4,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_hold_flag,
    input  logic              trap_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              jump_bp,
    input  logic [ADDR_W-1:0] bp_addr_i,
    input  logic              fetch_ready_i,
    output logic              fetch_valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              redirect_o,
    output logic              pend_o,
    input  logic              ras_push_i,
    input  logic              ras_pop_i,
    output logic [ADDR_W-1:0] ras_top_o,
    output logic              ras_valid_o,
    output logic [1:0]        state_dbg
);

    // Request handshake: imem samples pc_o only on an edge where fetch_valid_o and
    // fetch_ready_i are both high; while valid is high and ready low, pc_o stays stable
    // unless a redirect replaces it.

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] INC_V      = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INC - 1));

    state_t            state;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_trap;

    logic              fire;
    logic              run_adv;
    logic              live_redir;
    logic [ADDR_W-1:0] live_target;
    logic              pend_keep;

    assign state_dbg  = state;
    assign fire       = fetch_valid_o & fetch_ready_i;
    assign run_adv    = (state == S_RUN) & ~pc_hold_flag;
    assign live_redir = trap_i | jump_flag_i | jump_bp;
    // A buffered trap outranks any later non-trap redirect captured during the same hold.
    assign pend_keep  = pend_o & pend_trap & ~trap_i;

    always_comb begin
        live_target = bp_addr_i;
        if (trap_i)
            live_target = trap_addr_i;
        else if (jump_flag_i)
            live_target = pc_i;
        live_target = live_target & ALIGN_MASK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_BOOT;
            pc_o          <= RESET_ADDR;
            fetch_valid_o <= 1'b0;
            redirect_o    <= 1'b0;
            pend_o        <= 1'b0;
            pend_addr     <= '0;
            pend_trap     <= 1'b0;
        end else begin
            redirect_o <= 1'b0;

            case (state)
                S_BOOT: begin
                    if (pc_hold_flag) begin
                        state         <= S_HOLD;
                        fetch_valid_o <= 1'b0;
                    end else begin
                        state         <= S_RUN;
                        fetch_valid_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (pc_hold_flag) begin
                        state         <= S_HOLD;
                        fetch_valid_o <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!pc_hold_flag) begin
                        state         <= S_RUN;
                        fetch_valid_o <= 1'b1;
                    end
                end
                default: begin
                    state         <= S_BOOT;
                    fetch_valid_o <= 1'b0;
                end
            endcase

            if (run_adv) begin
                if (live_redir) begin
                    pc_o       <= live_target;
                    redirect_o <= 1'b1;
                    pend_o     <= 1'b0;
                    pend_trap  <= 1'b0;
                end else if (pend_o) begin
                    pc_o       <= pend_addr;
                    redirect_o <= 1'b1;
                    pend_o     <= 1'b0;
                    pend_trap  <= 1'b0;
                end else if (fire) begin
                    pc_o <= pc_o + INC_V;
                end
            end else if (live_redir && !pend_keep) begin
                // Not advancing (stall, boot or hold release): buffer the redirect.
                pend_o    <= 1'b1;
                pend_addr <= live_target;
                pend_trap <= trap_i;
            end
        end
    end

`ifdef PC_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [PTR_W-1:0]  ras_ptr_inc;
    logic [PTR_W-1:0]  ras_ptr_dec;
    logic [PTR_W:0]    ras_cnt;
    logic [ADDR_W-1:0] ras_ret;
    logic              ras_replace;

    assign ras_ptr_inc = ras_ptr + 1'b1;
    assign ras_ptr_dec = ras_ptr - 1'b1;
    assign ras_ret     = pc_o + INC_V;
    assign ras_replace = ras_push_i & ras_pop_i & (ras_cnt != '0);
    assign ras_top_o   = ras_mem[ras_ptr];
    assign ras_valid_o = (ras_cnt != '0);

    // Circular buffer: a push when full simply wraps onto the oldest slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_replace) begin
            ras_ptr <= ras_ptr;
        end else if (ras_push_i) begin
            ras_ptr <= ras_ptr_inc;
            if (ras_cnt != CNT_MAX)
                ras_cnt <= ras_cnt + 1'b1;
        end else if (ras_pop_i && ras_cnt != '0) begin
            ras_ptr <= ras_ptr_dec;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_replace)
            ras_mem[ras_ptr] <= ras_ret;
        else if (ras_push_i)
            ras_mem[ras_ptr_inc] <= ras_ret;
    end
`else
    logic ras_unused;

    assign ras_unused  = ras_push_i ^ ras_pop_i;
    assign ras_top_o   = '0;
    assign ras_valid_o = 1'b0;
`endif

endmodule
